wb_stream_writer_core: RTL and testbench

Memory-to-stream DMA engine: fetches a buffer from memory over a Wishbone B3 master using incrementing bursts and emits the words on a valid/ready stream master. It is the outbound counterpart of the stream-to-memory writer path. It sits between system memory (Wishbone master port) and a stream consumer. Software configures it through a Wishbone slave register bank.

---
 rtl/wb_stream_writer_core_if.sv | 53 +++++
 rtl/wb_stream_writer_core.sv | 183 ++++++++++++++++++
 tb/tb_wb_stream_writer_core.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stream_writer_core_if.sv
// rtl/wb_stream_writer_core_if.sv - memory master, config slave and stream signal bundle
interface wb_stream_writer_core_if #(
    parameter int WB_DW = 32,
    parameter int WB_AW = 32
);
    logic [WB_AW-1:0]   wbm_adr_o;
    logic [WB_DW-1:0]   wbm_dat_o;
    logic [WB_DW/8-1:0] wbm_sel_o;
    logic               wbm_we_o;
    logic               wbm_cyc_o;
    logic               wbm_stb_o;
    logic [2:0]         wbm_cti_o;
    logic [1:0]         wbm_bte_o;
    logic [WB_DW-1:0]   wbm_dat_i;
    logic               wbm_ack_i;
    logic               wbm_err_i;
    logic               wbm_rty_i;

    logic [WB_DW-1:0]   stream_m_data_o;
    logic               stream_m_valid_o;
    logic               stream_m_ready_i;

    logic [WB_AW-1:0]   wbs_adr_i;
    logic [WB_DW-1:0]   wbs_dat_i;
    logic [WB_DW/8-1:0] wbs_sel_i;
    logic               wbs_we_i;
    logic               wbs_cyc_i;
    logic               wbs_stb_i;
    logic [2:0]         wbs_cti_i;
    logic [1:0]         wbs_bte_i;
    logic [WB_DW-1:0]   wbs_dat_o;
    logic               wbs_ack_o;
    logic               wbs_err_o;
    logic               wbs_rty_o;

    modport master (
        output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_cti_o, wbm_bte_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i,
        output stream_m_data_o, stream_m_valid_o,
        input  stream_m_ready_i,
        input  wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_cyc_i, wbs_stb_i, wbs_cti_i, wbs_bte_i,
        output wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_rty_o
    );

    modport slave (
        input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_cti_o, wbm_bte_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i,
        input  stream_m_data_o, stream_m_valid_o,
        output stream_m_ready_i,
        output wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_cyc_i, wbs_stb_i, wbs_cti_i, wbs_bte_i,
        input  wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_rty_o
    );
endinterface

// File: rtl/wb_stream_writer_core.sv
// rtl/wb_stream_writer_core.sv - memory-to-stream DMA: Wishbone burst reads into a FWFT FIFO feeding a stream
module wb_stream_writer_core #(
    parameter int WB_DW         = 32,
    parameter int WB_AW         = 32,
    parameter int FIFO_AW       = 4,
    parameter int MAX_BURST_LEN = 2**FIFO_AW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   irq_o,
    wb_stream_writer_core_if.master bus
);
    localparam int DEPTH = 2**FIFO_AW;
    localparam int BYTES = WB_DW/8;
    localparam logic [FIFO_AW:0] DEPTH_W  = DEPTH;
    localparam logic [2:0]       CTI_INCR = 3'b010;
    localparam logic [2:0]       CTI_EOB  = 3'b111;

    typedef enum logic [1:0] {IDLE, WAIT, BURST, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [WB_AW-1:0] start_adr_q, buf_size_q, burst_size_q, tx_cnt_q, burst_left_q;
    logic             irq_q, err_q, zero_pend_q;
    logic             wbs_ack_q;
    logic [WB_DW-1:0] wbs_dat_q, rd_data;

    logic [WB_DW-1:0]   fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   fifo_cnt_q, free_space;

    logic             busy, in_burst, req, wr, ctrl_wr, start_req;
    logic             push, pop, fifo_valid, load_burst, finish, abort;
    logic [2:0]       reg_sel;
    logic [WB_AW-1:0] bs, rem, burst_len;

    // Config slave: one request per ack, so ack can never sit high two cycles in a row.
    assign req       = bus.wbs_cyc_i & bus.wbs_stb_i & ~wbs_ack_q;
    assign wr        = req & bus.wbs_we_i;
    assign reg_sel   = bus.wbs_adr_i[4:2];
    assign busy      = (state_q != IDLE);
    assign ctrl_wr   = wr && (reg_sel == 3'd0);
    assign start_req = ctrl_wr && bus.wbs_dat_i[0] && !busy;

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            3'd0:    rd_data = WB_DW'({err_q, irq_q, busy});
            3'd1:    rd_data = WB_DW'(start_adr_q);
            3'd2:    rd_data = WB_DW'(buf_size_q);
            3'd3:    rd_data = WB_DW'(burst_size_q);
            3'd4:    rd_data = WB_DW'(tx_cnt_q);
            default: rd_data = '0;
        endcase
    end

    always_comb begin
        bs        = (burst_size_q == '0) ? WB_AW'(1) : burst_size_q;
        rem       = buf_size_q - tx_cnt_q;
        burst_len = (bs < rem) ? bs : rem;
        if (burst_len > WB_AW'(MAX_BURST_LEN)) burst_len = WB_AW'(MAX_BURST_LEN);
    end

    assign fifo_valid = (fifo_cnt_q != '0);
    assign pop        = fifo_valid & bus.stream_m_ready_i;
    assign free_space = DEPTH_W - fifo_cnt_q;

    always_comb begin
        state_d    = state_q;
        push       = 1'b0;
        load_burst = 1'b0;
        finish     = 1'b0;
        abort      = 1'b0;
        case (state_q)
            IDLE: if (start_req && buf_size_q != '0) state_d = WAIT;
            WAIT: begin
                // Only launch once the whole burst is guaranteed a FIFO slot.
                if (WB_AW'(free_space) >= burst_len) begin
                    load_burst = 1'b1;
                    state_d    = BURST;
                end
            end
            BURST: begin
                if (bus.wbm_err_i) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (bus.wbm_ack_i) begin
                    push = 1'b1;
                    if (burst_left_q == WB_AW'(1))
                        state_d = (tx_cnt_q + WB_AW'(1) == buf_size_q) ? DRAIN : WAIT;
                end
            end
            DRAIN: begin
                // Finish on the edge of the last pop so irq follows the final handshake directly.
                if (fifo_cnt_q == '0 || (fifo_cnt_q == (FIFO_AW+1)'(1) && pop)) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            start_adr_q  <= '0;
            buf_size_q   <= '0;
            burst_size_q <= '0;
            tx_cnt_q     <= '0;
            burst_left_q <= '0;
            irq_q        <= 1'b0;
            err_q        <= 1'b0;
            zero_pend_q  <= 1'b0;
            wbs_ack_q    <= 1'b0;
            wbs_dat_q    <= '0;
        end else begin
            state_q     <= state_d;
            wbs_ack_q   <= req;
            zero_pend_q <= start_req && (buf_size_q == '0);
            if (req) wbs_dat_q <= rd_data;
            if (wr && !busy) begin
                case (reg_sel)
                    3'd1:    start_adr_q  <= WB_AW'(bus.wbs_dat_i);
                    3'd2:    buf_size_q   <= WB_AW'(bus.wbs_dat_i);
                    3'd3:    burst_size_q <= WB_AW'(bus.wbs_dat_i);
                    default: ;
                endcase
            end
            if (start_req) begin
                tx_cnt_q <= '0;
                err_q    <= 1'b0;
            end
            if (load_burst) burst_left_q <= burst_len;
            if (push) begin
                tx_cnt_q     <= tx_cnt_q + WB_AW'(1);
                burst_left_q <= burst_left_q - WB_AW'(1);
            end
            if (abort) err_q <= 1'b1;
            if (ctrl_wr && bus.wbs_dat_i[1]) irq_q <= 1'b0;
            if (abort || finish || zero_pend_q) irq_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + (FIFO_AW+1)'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - (FIFO_AW+1)'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= bus.wbm_dat_i;
    end

    assign in_burst             = (state_q == BURST);
    assign bus.wbm_adr_o        = in_burst ? start_adr_q + tx_cnt_q * WB_AW'(BYTES) : '0;
    assign bus.wbm_dat_o        = '0;
    assign bus.wbm_sel_o        = {(WB_DW/8){in_burst}};
    assign bus.wbm_we_o         = 1'b0;
    assign bus.wbm_cyc_o        = in_burst;
    assign bus.wbm_stb_o        = in_burst;
    assign bus.wbm_cti_o        = !in_burst ? 3'b000 : (burst_left_q == WB_AW'(1)) ? CTI_EOB : CTI_INCR;
    assign bus.wbm_bte_o        = 2'b00;
    assign bus.stream_m_valid_o = fifo_valid;
    assign bus.stream_m_data_o  = fifo_valid ? fifo_mem[rd_ptr_q] : '0;
    assign bus.wbs_dat_o        = wbs_dat_q;
    assign bus.wbs_ack_o        = wbs_ack_q;
    assign bus.wbs_err_o        = 1'b0;
    assign bus.wbs_rty_o        = 1'b0;
    assign irq_o                = irq_q;

    logic unused_wbs;
    assign unused_wbs = ^{bus.wbs_adr_i, bus.wbs_sel_i, bus.wbs_cti_i, bus.wbs_bte_i};
endmodule

// File: tb/tb_wb_stream_writer_core.sv
// tb/tb_wb_stream_writer_core.sv - directed self-checking bench for wb_stream_writer_core
`timescale 1ns/1ps
module tb_wb_stream_writer_core;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic irq;
    always #5 clk = ~clk;

    wb_stream_writer_core_if bus ();
    wb_stream_writer_core dut (.clk(clk), .rst_n(rst_n), .irq_o(irq), .bus(bus));

    int vectors = 0;
    int miscompares = 0;

    // Zero-wait memory returning its own address, with one-shot err/rty injection by beat number.
    int ack_total = 0, st_total = 0, rty_seen = 0, rty_arm = 0;
    int err_at = -1, rty_at = -1;
    logic [31:0] ack_adr [512];
    logic [2:0]  ack_cti [512];
    logic [31:0] st_dat  [512];
    logic [31:0] rty_adr = '0;
    logic        m_req, m_err, m_rty;

    always_comb begin
        m_req = bus.wbm_cyc_o && bus.wbm_stb_o;
        m_err = m_req && (ack_total == err_at);
        m_rty = m_req && (ack_total == rty_at) && (rty_seen != rty_arm);
        bus.wbm_dat_i = bus.wbm_adr_o;
        bus.wbm_err_i = m_err;
        bus.wbm_rty_i = m_rty;
        bus.wbm_ack_i = m_req && !m_err && !m_rty;
    end

    always @(posedge clk) begin
        if (bus.wbm_ack_i) begin
            ack_adr[ack_total] <= bus.wbm_adr_o;
            ack_cti[ack_total] <= bus.wbm_cti_o;
            ack_total          <= ack_total + 1;
        end
        if (bus.wbm_rty_i) begin
            rty_adr  <= bus.wbm_adr_o;
            rty_seen <= rty_seen + 1;
        end
        if (bus.stream_m_valid_o && bus.stream_m_ready_i) begin
            st_dat[st_total] <= bus.stream_m_data_o;
            st_total         <= st_total + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                           output logic [31:0] rdat);
        bit got = 0;
        rdat = '0;
        @(negedge clk);
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = wdat;
        bus.wbs_we_i  = we;
        bus.wbs_sel_i = 4'hf;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (bus.wbs_ack_o) begin
                got  = 1;
                rdat = bus.wbs_dat_o;
            end
        end
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        if (!got) chk("wbs_ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] d;
        wb_xfer(1'b1, adr, dat, d);
    endtask

    task automatic rd(input logic [31:0] adr, output logic [31:0] dat);
        wb_xfer(1'b0, adr, '0, dat);
    endtask

    task automatic wait_irq(input int budget, input string tag);
        for (int i = 0; i < budget && !irq; i++) begin
            @(posedge clk); #1;
        end
        chk(tag, {31'd0, irq}, 32'd1);
    endtask

    task automatic setup(input logic [31:0] sa, input logic [31:0] bsz, input logic [31:0] burst);
        wr(32'h04, sa);
        wr(32'h08, bsz);
        wr(32'h0C, burst);
    endtask

    logic [31:0] r;
    int a0, s0;

    initial begin
        bus.wbs_adr_i = '0; bus.wbs_dat_i = '0; bus.wbs_sel_i = '0; bus.wbs_we_i = 1'b0;
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_cti_i = '0; bus.wbs_bte_i = '0;
        bus.stream_m_ready_i = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cyc", {31'd0, bus.wbm_cyc_o}, 32'd0);
        chk("rst_cti", {29'd0, bus.wbm_cti_o}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_valid", {31'd0, bus.stream_m_valid_o}, 32'd0);
        chk("rst_wbs_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
        rst_n = 1'b1;
        rd(32'h00, r); chk("rst_ctrl", r, 32'd0);
        rd(32'h10, r); chk("rst_txcnt", r, 32'd0);

        // Basic: 8 words in bursts of 4
        setup(32'h1000, 32'd8, 32'd4);
        bus.stream_m_ready_i = 1'b1;
        a0 = ack_total; s0 = st_total;
        wr(32'h00, 32'h1);
        chk("basic_cyc_at_ack", {31'd0, bus.wbm_cyc_o}, 32'd0);
        @(posedge clk); #1;
        chk("basic_cyc_start", {31'd0, bus.wbm_cyc_o}, 32'd1);
        chk("basic_first_adr", bus.wbm_adr_o, 32'h1000);
        for (int i = 0; i < 100; i++) begin
            if (st_total - s0 == 8) break;
            @(posedge clk); #1;
        end
        chk("basic_words", st_total - s0, 32'd8);
        chk("basic_irq_after_last", {31'd0, irq}, 32'd1);
        chk("basic_acks", ack_total - a0, 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("basic_adr%0d", i), ack_adr[a0+i], 32'h1000 + 4*i);
            chk($sformatf("basic_cti%0d", i), {29'd0, ack_cti[a0+i]}, (i % 4 == 3) ? 32'd7 : 32'd2);
            chk($sformatf("basic_dat%0d", i), st_dat[s0+i], 32'h1000 + 4*i);
        end
        rd(32'h00, r); chk("basic_ctrl", r, 32'h2);
        wr(32'h00, 32'h2);
        chk("basic_irq_clr", {31'd0, irq}, 32'd0);

        // Remainder: 10 words as 4,4,2
        setup(32'h2000, 32'd10, 32'd4);
        a0 = ack_total; s0 = st_total;
        wr(32'h00, 32'h1);
        wait_irq(200, "rem_irq");
        chk("rem_acks", ack_total - a0, 32'd10);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("rem_cti%0d", i), {29'd0, ack_cti[a0+i]},
                (i == 3 || i == 7 || i == 9) ? 32'd7 : 32'd2);
            chk($sformatf("rem_dat%0d", i), st_dat[s0+i], 32'h2000 + 4*i);
        end
        rd(32'h10, r); chk("rem_txcnt", r, 32'd10);
        wr(32'h00, 32'h2);

        // Backpressure: FIFO fills at 16, writes while busy are ignored
        bus.stream_m_ready_i = 1'b0;
        setup(32'h3000, 32'd40, 32'd4);
        a0 = ack_total; s0 = st_total;
        wr(32'h00, 32'h1);
        repeat (200) @(posedge clk);
        #1;
        chk("bp_acks_full", ack_total - a0, 32'd16);
        chk("bp_cyc_idle", {31'd0, bus.wbm_cyc_o}, 32'd0);
        chk("bp_valid", {31'd0, bus.stream_m_valid_o}, 32'd1);
        chk("bp_head", bus.stream_m_data_o, 32'h3000);
        wr(32'h04, 32'hDEAD0000);
        wr(32'h08, 32'd5);
        wr(32'h00, 32'h1);
        rd(32'h04, r); chk("busy_start_adr", r, 32'h3000);
        rd(32'h08, r); chk("busy_buf_size", r, 32'd40);
        rd(32'h00, r); chk("bp_ctrl_busy", r, 32'h1);
        bus.stream_m_ready_i = 1'b1;
        wait_irq(1000, "bp_irq");
        chk("bp_acks", ack_total - a0, 32'd40);
        chk("bp_words", st_total - s0, 32'd40);
        for (int i = 0; i < 40; i++)
            chk($sformatf("bp_dat%0d", i), st_dat[s0+i], 32'h3000 + 4*i);
        wr(32'h00, 32'h2);

        // BUF_SIZE = 0
        wr(32'h08, 32'd0);
        a0 = ack_total;
        wr(32'h00, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        chk("zero_irq", {31'd0, irq}, 32'd1);
        chk("zero_acks", ack_total - a0, 32'd0);
        rd(32'h00, r); chk("zero_ctrl", r, 32'h2);
        wr(32'h00, 32'h2);

        // Error on beat 3
        bus.stream_m_ready_i = 1'b0;
        setup(32'h4000, 32'd8, 32'd4);
        a0 = ack_total; s0 = st_total;
        err_at = ack_total + 2;
        wr(32'h00, 32'h1);
        wait_irq(100, "err_irq");
        chk("err_cyc", {31'd0, bus.wbm_cyc_o}, 32'd0);
        chk("err_valid", {31'd0, bus.stream_m_valid_o}, 32'd0);
        chk("err_acks", ack_total - a0, 32'd2);
        rd(32'h00, r); chk("err_ctrl", r, 32'h6);
        err_at = -1;
        bus.stream_m_ready_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("err_stream_words", st_total - s0, 32'd0);
        wr(32'h00, 32'h2);

        // Retry on beat 2
        setup(32'h6000, 32'd4, 32'd4);
        a0 = ack_total; s0 = st_total;
        rty_at = ack_total + 1;
        rty_arm = rty_seen + 1;
        wr(32'h00, 32'h1);
        wait_irq(100, "rty_irq");
        chk("rty_count", rty_seen, rty_arm);
        chk("rty_adr", rty_adr, 32'h6004);
        chk("rty_acks", ack_total - a0, 32'd4);
        chk("rty_words", st_total - s0, 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rty_dat%0d", i), st_dat[s0+i], 32'h6000 + 4*i);
        rd(32'h00, r); chk("rty_ctrl_err_clr", r, 32'h2);
        rty_at = -1;
        wr(32'h00, 32'h2);

        // Reset mid-burst, then a fresh transfer
        bus.stream_m_ready_i = 1'b0;
        setup(32'h7000, 32'd8, 32'd4);
        a0 = ack_total;
        wr(32'h00, 32'h1);
        for (int i = 0; i < 50 && (ack_total - a0) < 2; i++) begin
            @(posedge clk); #1;
        end
        chk("mid_cyc_before_rst", {31'd0, bus.wbm_cyc_o}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_cyc", {31'd0, bus.wbm_cyc_o}, 32'd0);
        chk("mid_rst_stb", {31'd0, bus.wbm_stb_o}, 32'd0);
        chk("mid_rst_adr", bus.wbm_adr_o, 32'd0);
        chk("mid_rst_cti", {29'd0, bus.wbm_cti_o}, 32'd0);
        chk("mid_rst_valid", {31'd0, bus.stream_m_valid_o}, 32'd0);
        chk("mid_rst_data", bus.stream_m_data_o, 32'd0);
        rst_n = 1'b1;
        rd(32'h04, r); chk("mid_rst_start_adr", r, 32'd0);
        bus.stream_m_ready_i = 1'b1;
        setup(32'h8000, 32'd4, 32'd2);
        a0 = ack_total; s0 = st_total;
        wr(32'h00, 32'h1);
        wait_irq(100, "post_rst_irq");
        chk("post_rst_words", st_total - s0, 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("post_rst_cti%0d", i), {29'd0, ack_cti[a0+i]}, (i % 2 == 1) ? 32'd7 : 32'd2);
            chk($sformatf("post_rst_dat%0d", i), st_dat[s0+i], 32'h8000 + 4*i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
